// File: rtl/xif_copro_issue_predecoder.sv
// Multi-channel registered XIF offload predecoder with outstanding-credit gating.
// Optional statistics counters are enabled with `define XIF_COPRO_PRD_STATS_EN.

package xif_copro_predecoder_pkg;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic       loadstore;
    logic [2:0] use_gprs;   // bit0 rs1, bit1 rs2, bit2 rs3
  } prd_rsp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] instr_mask;
    prd_rsp_t    prd_rsp;
  } offload_instr_t;

  localparam int NUM_OFFLOAD = 5;

  // custom-0 ALU ops, custom-1 stores, custom-3 R4 ops; entry 4 overlaps entry 0 to add rs3
  localparam offload_instr_t OFFLOAD_INSTR [NUM_OFFLOAD] = '{
    '{instr: 32'h0000_000B, instr_mask: 32'h0000_707F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0, use_gprs: 3'b011}},
    '{instr: 32'h0000_100B, instr_mask: 32'h0000_707F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0, use_gprs: 3'b001}},
    '{instr: 32'h0000_002B, instr_mask: 32'h0000_007F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b1, use_gprs: 3'b011}},
    '{instr: 32'h0000_007B, instr_mask: 32'h0000_007F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0, use_gprs: 3'b111}},
    '{instr: 32'h0200_000B, instr_mask: 32'hFE00_707F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b0, use_gprs: 3'b100}}
  };

endpackage

module xif_copro_issue_predecoder_chk #(
  parameter int CNT_W           = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [CNT_W-1:0] outstanding
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // The credit counter must never pass the in-flight limit
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) outstanding <= MAX_CNT);

endmodule

module xif_copro_issue_predecoder
  import xif_copro_predecoder_pkg::*;
#(
  parameter  int NUM_CH          = 2,
  parameter  int ID_W            = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      req_valid_i,
  output logic [NUM_CH-1:0]      req_ready_o,
  input  logic [NUM_CH*32-1:0]   req_instr_i,
  input  logic [NUM_CH*ID_W-1:0] req_id_i,
  output logic [NUM_CH-1:0]      rsp_valid_o,
  input  logic [NUM_CH-1:0]      rsp_ready_i,
  output logic [NUM_CH-1:0]      rsp_accept_o,
  output logic [NUM_CH-1:0]      rsp_writeback_o,
  output logic [NUM_CH-1:0]      rsp_loadstore_o,
  output logic [NUM_CH*3-1:0]    rsp_use_gprs_o,
  output logic [NUM_CH*ID_W-1:0] rsp_id_o,
  input  logic                   retire_i,
  output logic [CNT_W-1:0]       outstanding_o,
`ifdef XIF_COPRO_PRD_STATS_EN
  output logic [15:0]            stat_accept_o,
  output logic [15:0]            stat_reject_o,
`endif
  output logic                   underflow_o
);

  // Grants only happen while outstanding+granted < MAX, so CNT_W bits never overflow
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  prd_rsp_t          dec [NUM_CH];
  logic [NUM_CH-1:0] hs;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] reject;
  logic [CNT_W-1:0]  granted;
  logic [CNT_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_next;
  logic              uf_set;

  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign hs          = req_valid_i & req_ready_o;

  // Table match per channel; fields of all hitting entries are ORed
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      dec[c] = prd_rsp_t'('0);
      for (int i = 0; i < NUM_OFFLOAD; i++) begin
        dec[c] = dec[c] |
                 (((OFFLOAD_INSTR[i].instr_mask & req_instr_i[32*c +: 32]) == OFFLOAD_INSTR[i].instr)
                  ? OFFLOAD_INSTR[i].prd_rsp : prd_rsp_t'('0));
      end
    end
  end

  // Credit arbitration in channel order, then netting against retire
  always_comb begin
    granted = '0;
    grant   = '0;
    reject  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs[c] && dec[c].accept) begin
        if ((outstanding_o + granted) < MAX_CNT) begin
          grant[c] = 1'b1;
          granted  = granted + ONE;
        end else begin
          reject[c] = 1'b1;
        end
      end else begin
        grant[c] = 1'b0;
      end
    end
    cnt_sum = outstanding_o + granted;
    if (retire_i && (cnt_sum != '0)) begin
      cnt_next = cnt_sum - ONE;
    end else begin
      cnt_next = cnt_sum;
    end
    uf_set = retire_i && (cnt_sum == '0);
  end

  // Response registers, credit counter and sticky underflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o     <= '0;
      rsp_accept_o    <= '0;
      rsp_writeback_o <= '0;
      rsp_loadstore_o <= '0;
      rsp_use_gprs_o  <= '0;
      rsp_id_o        <= '0;
      outstanding_o   <= '0;
      underflow_o     <= 1'b0;
    end else begin
      outstanding_o <= cnt_next;
      underflow_o   <= underflow_o | uf_set;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[c]) begin
          rsp_valid_o[c]            <= 1'b1;
          rsp_accept_o[c]           <= grant[c];
          rsp_writeback_o[c]        <= grant[c] & dec[c].writeback;
          rsp_loadstore_o[c]        <= grant[c] & dec[c].loadstore;
          rsp_use_gprs_o[3*c +: 3]  <= grant[c] ? dec[c].use_gprs : 3'b000;
          rsp_id_o[ID_W*c +: ID_W]  <= req_id_i[ID_W*c +: ID_W];
        end else if (rsp_ready_i[c]) begin
          rsp_valid_o[c] <= 1'b0;
        end else begin
          rsp_valid_o[c] <= rsp_valid_o[c];
        end
      end
    end
  end

`ifdef XIF_COPRO_PRD_STATS_EN
  function automatic logic [2:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      p = p + 3'(v[i]);
    end
    return p;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating grant/reject event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_accept_o <= 16'h0000;
      stat_reject_o <= 16'h0000;
    end else begin
      stat_accept_o <= sat_add(stat_accept_o, popcnt(grant));
      stat_reject_o <= sat_add(stat_reject_o, popcnt(reject));
    end
  end
`endif

  xif_copro_issue_predecoder_chk #(
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .outstanding (outstanding_o)
  );

endmodule

// File: tb/tb_xif_copro_issue_predecoder.sv
// Self-checking bench: directed sequences, decode vector table and a randomized run
// against a cycle-level behavioural model of the predecoder.
module tb_xif_copro_issue_predecoder;

  localparam int NUM_CH = 2;
  localparam int ID_W   = 4;
  localparam int MAXO   = 3;
  localparam int CNT_W  = 2;

  localparam logic [31:0] I_ALU  = 32'h00B5_058B;  // custom-0 f3=0
  localparam logic [31:0] I_ST   = 32'h00A5_A02B;  // custom-1 store
  localparam logic [31:0] I_R4   = 32'h1CB5_05FB;  // custom-3 R4
  localparam logic [31:0] I_ADDI = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_CH*32-1:0]   req_instr;
  logic [NUM_CH*ID_W-1:0] req_id, rsp_id;
  logic [NUM_CH-1:0]      rsp_accept, rsp_writeback, rsp_loadstore;
  logic [NUM_CH*3-1:0]    rsp_use_gprs;
  logic                   retire;
  logic [CNT_W-1:0]       outstanding;
  logic                   underflow;
`ifdef XIF_COPRO_PRD_STATS_EN
  logic [15:0]            stat_accept, stat_reject;
`endif

  always #5 clk = ~clk;

  xif_copro_issue_predecoder #(.NUM_CH(NUM_CH), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_instr_i     (req_instr),
    .req_id_i        (req_id),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_accept_o    (rsp_accept),
    .rsp_writeback_o (rsp_writeback),
    .rsp_loadstore_o (rsp_loadstore),
    .rsp_use_gprs_o  (rsp_use_gprs),
    .rsp_id_o        (rsp_id),
    .retire_i        (retire),
    .outstanding_o   (outstanding),
`ifdef XIF_COPRO_PRD_STATS_EN
    .stat_accept_o   (stat_accept),
    .stat_reject_o   (stat_reject),
`endif
    .underflow_o     (underflow)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  logic       mv  [NUM_CH];
  logic [5:0] mp  [NUM_CH];   // {accept, writeback, loadstore, use_gprs}
  logic [3:0] mid [NUM_CH];
  int         mcnt, macc, mrej;
  logic       muf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offload table behaviour: custom-0 f3=0 ALU (+rs3 when funct7=1), custom-0 f3=1,
  // custom-1 stores, custom-3 R4 ops; anything else is not offloaded.
  function automatic logic [5:0] ref_dec(input logic [31:0] w);
    logic [5:0] r;
    r = 6'b000000;
    case (w[6:0])
      7'h0B: begin
        if (w[14:12] == 3'd0) r = (w[31:25] == 7'h01) ? 6'b110111 : 6'b110011;
        else if (w[14:12] == 3'd1) r = 6'b110001;
        else r = 6'b000000;
      end
      7'h2B:   r = 6'b101011;
      7'h7B:   r = 6'b110111;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: begin w[6:0] = 7'h0B; w[14:12] = 3'($urandom_range(0, 2)); end
      1: begin w[6:0] = 7'h0B; w[14:12] = 3'd0; w[31:25] = 7'h01; end
      2: w[6:0] = 7'h2B;
      3: w[6:0] = 7'h7B;
      4: w = I_ADDI;
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      mv[c] = 1'b0; mp[c] = 6'b0; mid[c] = 4'h0;
    end
    mcnt = 0; macc = 0; mrej = 0; muf = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [3:0] id0, input logic [3:0] id1,
                       input logic [1:0] rr, input logic ret);
    req_valid = v; req_instr = {i1, i0}; req_id = {id1, id0}; rsp_ready = rr; retire = ret;
    #1;
  endtask

  task automatic compare_all();
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("rsp_valid[%0d]", c), 32'(rsp_valid[c]), 32'(mv[c]));
      chk($sformatf("rsp_fields[%0d]", c),
          32'({rsp_accept[c], rsp_writeback[c], rsp_loadstore[c], rsp_use_gprs[3*c +: 3]}), 32'(mp[c]));
      chk($sformatf("rsp_id[%0d]", c), 32'(rsp_id[ID_W*c +: ID_W]), 32'(mid[c]));
    end
    chk("outstanding", 32'(outstanding), 32'(mcnt));
    chk("underflow", 32'(underflow), 32'(muf));
`ifdef XIF_COPRO_PRD_STATS_EN
    chk("stat_accept", 32'(stat_accept), 32'(macc));
    chk("stat_reject", 32'(stat_reject), 32'(mrej));
`endif
  endtask

  // One clock: predict from the current inputs, advance, compare
  task automatic tick();
    logic [1:0] hs;
    logic [5:0] d;
    int g, s;
    for (int c = 0; c < NUM_CH; c++) begin
      hs[c] = req_valid[c] && (!mv[c] || rsp_ready[c]);
      chk($sformatf("req_ready[%0d]", c), 32'(req_ready[c]), 32'(!mv[c] || rsp_ready[c]));
    end
    g = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      d = ref_dec(req_instr[32*c +: 32]);
      if (hs[c]) begin
        mv[c]  = 1'b1;
        mid[c] = req_id[ID_W*c +: ID_W];
        if (d[5] && (mcnt + g < MAXO)) begin
          mp[c] = d; g++;
          macc = (macc < 65535) ? macc + 1 : macc;
        end else begin
          if (d[5]) mrej = (mrej < 65535) ? mrej + 1 : mrej;
          mp[c] = 6'b0;
        end
      end else if (rsp_ready[c]) begin
        mv[c] = 1'b0;
      end
    end
    s = mcnt + g;
    if (retire) begin
      if (s > 0) s--;
      else muf = 1'b1;
    end
    mcnt = s;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    compare_all();
    chk("reset_req_ready", 32'(req_ready), 32'h3);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  id;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h00B5_058B, 4'h1, 6'b110011};
    vecs[1] = '{32'h02B5_058B, 4'h2, 6'b110111};
    vecs[2] = '{32'h00B5_158B, 4'h3, 6'b110001};
    vecs[3] = '{32'h00B5_258B, 4'h4, 6'b000000};
    vecs[4] = '{32'h00A5_A02B, 4'h5, 6'b101011};
    vecs[5] = '{32'hFFFF_FFFB, 4'h6, 6'b110111};
    vecs[6] = '{32'h0000_0013, 4'h7, 6'b000000};
    vecs[7] = '{32'h0000_0000, 4'h8, 6'b000000};
    vecs[8] = '{32'h0000_007F, 4'h9, 6'b000000};
    vecs[9] = '{32'hFE00_000B, 4'hA, 6'b110011};

    do_reset();

    // first accepted instruction, 1-cycle latency
    drive(2'b01, I_ALU, 32'h0, 4'h3, 4'h0, 2'b11, 1'b0); tick();
    chk("t1_valid", 32'(rsp_valid[0]), 32'h1);
    chk("t1_accept", 32'(rsp_accept[0]), 32'h1);
    chk("t1_id", 32'(rsp_id[3:0]), 32'h3);
    chk("t1_outstanding", 32'(outstanding), 32'h1);

    // unmatched ADDI on ch1
    drive(2'b10, 32'h0, I_ADDI, 4'h0, 4'h5, 2'b11, 1'b0); tick();
    chk("addi_valid", 32'(rsp_valid[1]), 32'h1);
    chk("addi_accept", 32'(rsp_accept[1]), 32'h0);
    chk("addi_fields", 32'({rsp_writeback[1], rsp_loadstore[1], rsp_use_gprs[5:3]}), 32'h0);
    chk("addi_outstanding", 32'(outstanding), 32'h1);

    // fill to one below the limit, then both channels compete for the last credit
    drive(2'b01, I_ST, 32'h0, 4'h6, 4'h0, 2'b11, 1'b0); tick();
    chk("fill_outstanding", 32'(outstanding), 32'h2);
    drive(2'b11, I_ALU, I_R4, 4'h7, 4'h8, 2'b11, 1'b0); tick();
    chk("race_acc0", 32'(rsp_accept[0]), 32'h1);
    chk("race_acc1", 32'(rsp_accept[1]), 32'h0);
    chk("race_fields1", 32'({rsp_writeback[1], rsp_loadstore[1], rsp_use_gprs[5:3]}), 32'h0);
    chk("race_outstanding", 32'(outstanding), 32'h3);
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1); tick();
    drive(2'b10, 32'h0, I_R4, 4'h0, 4'h8, 2'b11, 1'b0); tick();
    chk("retry_acc1", 32'(rsp_accept[1]), 32'h1);
    chk("retry_gprs1", 32'(rsp_use_gprs[5:3]), 32'h7);

    // output stall holds response; release takes the next request the same cycle
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1); tick();
    drive(2'b01, I_ST, 32'h0, 4'hA, 4'h0, 2'b10, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, I_ADDI, 32'h0, 4'hB, 4'h0, 2'b10, 1'b0);
      chk("stall_ready", 32'(req_ready[0]), 32'h0);
      tick();
      chk("stall_id", 32'(rsp_id[3:0]), 32'hA);
      chk("stall_ls", 32'({rsp_valid[0], rsp_accept[0], rsp_loadstore[0]}), 32'h7);
    end
    drive(2'b01, I_ADDI, 32'h0, 4'hC, 4'h0, 2'b11, 1'b0);
    chk("release_ready", 32'(req_ready[0]), 32'h1);
    tick();
    chk("release_id", 32'(rsp_id[3:0]), 32'hC);
    chk("release_valid", 32'(rsp_valid[0]), 32'h1);

    // netted retire+grant, then underflow
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1); tick();
    chk("pre_net", 32'(outstanding), 32'h2);
    drive(2'b01, I_ALU, 32'h0, 4'h1, 4'h0, 2'b11, 1'b1); tick();
    chk("net_outstanding", 32'(outstanding), 32'h2);
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1); tick(); tick();
    chk("drain_outstanding", 32'(outstanding), 32'h0);
    chk("no_underflow_yet", 32'(underflow), 32'h0);
    tick();
    chk("underflow_set", 32'(underflow), 32'h1);
    chk("underflow_cnt", 32'(outstanding), 32'h0);
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b0); tick();
    chk("underflow_sticky", 32'(underflow), 32'h1);

    // 3 grants and 2 credit rejects, then an asynchronous reset pulse
    do_reset();
    drive(2'b11, I_ALU, I_ST, 4'h1, 4'h2, 2'b11, 1'b0); tick();
    drive(2'b11, I_ALU, I_ST, 4'h3, 4'h4, 2'b11, 1'b0); tick();
    drive(2'b10, 32'h0, I_R4, 4'h0, 4'h5, 2'b11, 1'b0); tick();
    chk("stats_outstanding", 32'(outstanding), 32'h3);
`ifdef XIF_COPRO_PRD_STATS_EN
    chk("stat_accept_3", 32'(stat_accept), 32'h3);
    chk("stat_reject_2", 32'(stat_reject), 32'h2);
`endif
    rst = 1'b1;
    #2;
    chk("async_valid", 32'(rsp_valid), 32'h0);
    chk("async_outstanding", 32'(outstanding), 32'h0);
    chk("async_payload", 32'({rsp_accept, rsp_writeback, rsp_loadstore, rsp_use_gprs, rsp_id}), 32'h0);
`ifdef XIF_COPRO_PRD_STATS_EN
    chk("async_stats", 32'({stat_accept, stat_reject}), 32'h0);
`endif
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b0); tick();

    // decode vector table on ch0
    for (int v = 0; v < 10; v++) begin
      drive(2'b01, vecs[v].instr, 32'h0, vecs[v].id, 4'h0, 2'b11, 1'b0); tick();
      chk($sformatf("vec%0d_fields", v),
          32'({rsp_accept[0], rsp_writeback[0], rsp_loadstore[0], rsp_use_gprs[2:0]}), 32'(vecs[v].exp));
      chk($sformatf("vec%0d_id", v), 32'(rsp_id[3:0]), 32'(vecs[v].id));
      drive(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, vecs[v].exp[5]); tick();
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
            4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
